// File: rtl/serial_sum_collector_if.sv
// rtl/serial_sum_collector_if.sv - serial bit stream and parallel result handshake bundle
interface serial_sum_collector_if #(
    parameter int WIDTH = 4
);
    logic             sum_bit;
    logic             carry_bit;
    logic             bit_valid;
    logic             bit_ready;
    logic [WIDTH-1:0] result;
    logic             result_cout;
    logic             result_valid;
    logic             result_ready;

    // Collector side: consumes the serial stream, produces the result word.
    modport slave (
        input  sum_bit,
        input  carry_bit,
        input  bit_valid,
        output bit_ready,
        output result,
        output result_cout,
        output result_valid,
        input  result_ready
    );

    // Environment side: drives the serial stream, takes the result word.
    modport master (
        output sum_bit,
        output carry_bit,
        output bit_valid,
        input  bit_ready,
        input  result,
        input  result_cout,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/serial_sum_collector.sv
// rtl/serial_sum_collector.sv - deserialises an LSB-first adder sum stream (option: SUM_COLLECTOR_NO_BUBBLE_EN)
module serial_sum_collector #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    serial_sum_collector_if.slave    bus,
    output logic [$clog2(WIDTH)-1:0] bit_index,
    output logic [CNT_W-1:0]         words_done
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             bit_ready_c;
    logic             result_valid_c;
    logic             accept;
    logic             handoff;

    assign accept           = bus.bit_valid & bit_ready_c;
    assign handoff          = result_valid_c & bus.result_ready;
    assign bus.bit_ready    = bit_ready_c;
    assign bus.result_valid = result_valid_c;
    assign bus.result       = result_q;
    assign bus.result_cout  = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a word completes on the last accepted bit, leaves FULL on handoff; clear wins.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && bit_index == LAST_IDX) state_nx = FULL;
                FULL:    if (handoff) state_nx = COLLECT;
                default: state_nx = COLLECT;
            endcase
        end
    end

    // Handshake outputs decoded from state; the no-bubble build forwards result_ready to bit_ready.
    always_comb begin
        result_valid_c = (state == FULL);
`ifdef SUM_COLLECTOR_NO_BUBBLE_EN
        bit_ready_c    = (state == COLLECT) | bus.result_ready;
`else
        bit_ready_c    = (state == COLLECT);
`endif
    end

    // Datapath: shift register, bit counter, result capture and handoff counter.
    // The shift register is zeroed when a word completes, so a bit accepted on a
    // handoff edge (no-bubble build) shifts in exactly like bit 0 from COLLECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            bit_index  <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            words_done <= '0;
        end else if (clear) begin
            shreg     <= '0;
            bit_index <= '0;
        end else begin
            if (handoff) begin
                words_done <= words_done + CNT_W'(1);
            end
            if (accept) begin
                if (bit_index == LAST_IDX) begin
                    result_q  <= {bus.sum_bit, shreg[WIDTH-1:1]};
                    cout_q    <= bus.carry_bit;
                    bit_index <= '0;
                    shreg     <= '0;
                end else begin
                    shreg     <= {bus.sum_bit, shreg[WIDTH-1:1]};
                    bit_index <= bit_index + IDX_W'(1);
                end
            end
        end
    end
endmodule
